// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word loads and stores at any byte address
// into aligned word reads and writes on a word-only RAM. Narrow stores are
// read-modify-write, and an access that straddles a word boundary becomes two
// word accesses. One request is in flight at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_write, req_funct3    store/load select, RV32I width code
//   req_addr, req_wdata      byte address (any alignment), right-justified store data
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_fault     load result / fault flag, zero unless rsp_valid
//   mem_address              aligned RAM word address
//   mem_writeData            RAM write word
//   mem_funct3               always lw/sw
//   mem_memRead/mem_memWrite RAM enables, registered and one cycle wide
//   mem_readData             combinational RAM read data
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic [2:0]  mem_funct3,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_readData
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q, wr1_data_q;
  logic [2:0]  funct3_q, size_q;
  logic        write_q;

  logic [2:0]  req_size;
  logic        req_fault;
  logic [1:0]  off;
  logic [31:0] w0, w1;
  logic        split;
  logic [63:0] data_n, merged_c;
  logic [31:0] shifted, load_c;
  logic [2:0]  pos;

  assign mem_funct3 = 3'b010;

  // Request decode: access size and fault (range check in 33 bits, no wrap)
  always_comb begin
    req_size  = 3'd4;
    req_fault = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_size = 3'd1;
      3'b001, 3'b101: req_size = 3'd2;
      default:        req_size = 3'd4;
    endcase
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_fault = 1'b0;
      3'b100, 3'b101:         req_fault = req_write;
      default:                req_fault = 1'b1;
    endcase
    if (({1'b0, req_addr} + 33'(req_size)) > 33'(MEM_SIZE))
      req_fault = 1'b1;
  end

  assign off   = addr_q[1:0];
  assign w0    = {addr_q[31:2], 2'b00};
  assign w1    = w0 + 32'd4;
  assign split = (3'(off) + size_q) > 3'd4;

  // {hi,lo} as it will be after this cycle's read capture
  assign data_n = {(state == RD1) ? mem_readData : hi_q,
                   (state == RD0) ? mem_readData : lo_q};

  // Store merge: insert size bytes at byte offset off, little-endian
  always_comb begin
    merged_c = data_n;
    pos      = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < size_q) begin
        pos = 3'(off) + 3'(i);
        merged_c[{pos, 3'b000} +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Load extract with sign/zero extension
  always_comb begin
    shifted = 32'(data_n >> {off, 3'b000});
    case (funct3_q)
      3'b000:  load_c = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_c = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_c = {24'd0, shifted[7:0]};
      3'b101:  load_c = {16'd0, shifted[15:0]};
      default: load_c = shifted;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 32'd0;
      rsp_fault     <= 1'b0;
      mem_address   <= 32'd0;
      mem_writeData <= 32'd0;
      mem_memRead   <= 1'b0;
      mem_memWrite  <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      lo_q          <= 32'd0;
      hi_q          <= 32'd0;
      wr1_data_q    <= 32'd0;
      funct3_q      <= 3'd0;
      size_q        <= 3'd0;
      write_q       <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_fault    <= 1'b0;
      mem_memRead  <= 1'b0;
      mem_memWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            funct3_q  <= req_funct3;
            size_q    <= req_size;
            write_q   <= req_write;
            req_ready <= 1'b0;
            if (req_fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else begin
              state       <= RD0;
              mem_address <= {req_addr[31:2], 2'b00};
              mem_memRead <= 1'b1;
            end
          end
        end
        RD0, RD1: begin
          if (state == RD0) lo_q <= mem_readData;
          else              hi_q <= mem_readData;
          if (state == RD0 && split) begin
            state       <= RD1;
            mem_address <= w1;
            mem_memRead <= 1'b1;
          end else if (write_q) begin
            state         <= WR0;
            wr1_data_q    <= merged_c[63:32];
            mem_address   <= w0;
            mem_writeData <= merged_c[31:0];
            mem_memWrite  <= 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_c;
          end
        end
        WR0: begin
          if (split) begin
            state         <= WR1;
            mem_address   <= w1;
            mem_writeData <= wr1_data_q;
            mem_memWrite  <= 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        WR1: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM model, directed requests with
// hand-computed results pushed to a scoreboard, monitor checks responses.
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic [2:0]  mem_funct3;
  logic        mem_memRead, mem_memWrite;

  load_store_unit #(.MEM_SIZE(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_funct3(mem_funct3), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rd_cnt = 0, wr_cnt = 0, bad_cnt = 0;
  int   rd0, wr0;

  // RAM model: combinational word read, word write on clock edge
  logic [7:0] ram [128];
  logic [6:0] ra;
  assign ra = {mem_address[6:2], 2'b00};
  assign mem_readData = {ram[ra + 7'd3], ram[ra + 7'd2], ram[ra + 7'd1], ram[ra]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_memWrite) begin
      ram[ra]         <= mem_writeData[7:0];
      ram[ra + 7'd1]  <= mem_writeData[15:8];
      ram[ra + 7'd2]  <= mem_writeData[23:16];
      ram[ra + 7'd3]  <= mem_writeData[31:24];
    end
    if (mem_memRead)  rd_cnt <= rd_cnt + 1;
    if (mem_memWrite) wr_cnt <= wr_cnt + 1;
    if ((mem_memRead && mem_memWrite) ||
        ((mem_memRead || mem_memWrite) && mem_address[1:0] != 2'b00))
      bad_cnt <= bad_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    ram[a] = v[7:0]; ram[a+1] = v[15:8]; ram[a+2] = v[23:16]; ram[a+3] = v[31:24];
  endtask

  // Monitor: compare every response against the scoreboard head
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
        chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !req_ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: no response within 50 cycles (pending=%0d)", sb.size());
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_f, input int lat);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready stayed 0, expected 1");
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    e.rdata = exp_rd; e.fault = exp_f; e.acc = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done();
  endtask

  task automatic mark();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
  endtask

  task automatic chk_cnt(input string tag, input int rds, input int wrs);
    chk({tag, "_reads"},  32'(rd_cnt - rd0), 32'(rds));
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(wrs));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_rdwr", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_funct3", 32'(mem_funct3), 32'd2);
    rst = 1'b0;

    // Aligned load
    set_word(32'h10, 32'h11223344);
    mark(); issue(1'b0, 3'b010, 32'h10, 32'd0, 32'h11223344, 1'b0, 2);
    chk_cnt("lw_aligned", 1, 1 - 1);

    // Byte store, read-modify-write
    mark(); issue(1'b1, 3'b000, 32'h13, 32'h000000AB, 32'd0, 1'b0, 3);
    chk_cnt("sb", 1, 1);
    chk("sb_ram", word_at(32'h10), 32'hAB223344);

    // Split word load
    set_word(32'h0C, 32'hDDCCBBAA);
    set_word(32'h10, 32'h44332211);
    mark(); issue(1'b0, 3'b010, 32'h0E, 32'd0, 32'h2211DDCC, 1'b0, 3);
    chk_cnt("lw_split", 2, 0);

    // Sign/zero extension
    ram[32'h0F] = 8'h80;
    issue(1'b0, 3'b000, 32'h0F, 32'd0, 32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 3'b100, 32'h0F, 32'd0, 32'h00000080, 1'b0, 2);
    issue(1'b0, 3'b001, 32'h0E, 32'd0, 32'hFFFF80CC, 1'b0, 2);
    issue(1'b0, 3'b101, 32'h0F, 32'd0, 32'h00001180, 1'b0, 3);

    // Split half store
    mark(); issue(1'b1, 3'b001, 32'h0F, 32'h0000BEEF, 32'd0, 1'b0, 5);
    chk_cnt("sh_split", 2, 2);
    chk("sh_split_lo", word_at(32'h0C), 32'hEFCCBBAA);
    chk("sh_split_hi", word_at(32'h10), 32'h443322BE);

    // Aligned word store
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 3);
    chk("sw_ram", word_at(32'h20), 32'hCAFEF00D);

    // Top-of-memory boundary
    set_word(32'h7C, 32'h89ABCDEF);
    issue(1'b0, 3'b010, 32'h7C, 32'd0, 32'h89ABCDEF, 1'b0, 2);
    issue(1'b0, 3'b000, 32'h7F, 32'd0, 32'hFFFFFF89, 1'b0, 2);

    // Faults: no RAM traffic, response at T+1
    mark(); issue(1'b1, 3'b010, 32'h7E, 32'h12345678, 32'd0, 1'b1, 1);
    chk_cnt("fault_sw_range", 0, 0);
    chk("fault_sw_ram", word_at(32'h7C), 32'h89ABCDEF);
    mark(); issue(1'b0, 3'b011, 32'h00, 32'd0, 32'd0, 1'b1, 1);
    chk_cnt("fault_f3_011", 0, 0);
    mark(); issue(1'b0, 3'b101, 32'h7F, 32'd0, 32'd0, 1'b1, 1);
    mark(); issue(1'b1, 3'b100, 32'h00, 32'd0, 32'd0, 1'b1, 1);
    chk_cnt("fault_store_f3_100", 0, 0);
    mark(); issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b1, 1);
    chk_cnt("fault_wrap", 0, 0);

    // Reset during RD1 of a split store: no write, no response
    mark();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0F; req_wdata = 32'h00001234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rd1_read_addr", mem_address, 32'h10);
    chk("rd1_read_en", 32'(mem_memRead), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_mid_ram_lo", word_at(32'h0C), 32'hEFCCBBAA);
    chk("rst_mid_ram_hi", word_at(32'h10), 32'h443322BE);

    chk("pending_rsp", 32'(sb.size()), 32'd0);
    chk("mem_protocol_violations", 32'(bad_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
